// File: rtl/alu_seq_exec.sv
// Execute stage for the 8-bit register file: single-cycle logic/add ops, shift-add multiply.
// Define ALU_SEQ_DIV_EN to turn op 111 into a restoring divider (otherwise op 111 is PASS).
module alu_seq_exec #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock_reg,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_data1,
    input  logic [DATA_WIDTH-1:0] src_data2,
    input  logic [ADDR_WIDTH-1:0] dest_address,
    output logic                  busy,
    output logic                  done,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  flag_zero,
    output logic                  flag_carry
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [2:0] S_DIV  = 3'd4;
    localparam logic [2:0] OP_DIV = 3'b111;
`endif

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    logic [2:0]              state;
    logic [2:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]        cnt;

    logic [2*DATA_WIDTH-1:0] prod;
    logic [2*DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0]   mplier;
    logic [2*DATA_WIDTH-1:0] prod_next;

    logic [DATA_WIDTH:0]     sum_ext;
    logic [DATA_WIDTH:0]     diff_ext;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_carry;

`ifdef ALU_SEQ_DIV_EN
    logic [DATA_WIDTH-1:0]   rem;
    logic [DATA_WIDTH-1:0]   quo;
    logic [DATA_WIDTH:0]     rem_shift;
    logic [DATA_WIDTH:0]     rem_diff;
    logic                    no_borrow;
    logic [DATA_WIDTH-1:0]   rem_next;
    logic [DATA_WIDTH-1:0]   quo_next;
`endif

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_WB);
    assign write_enable = (state == S_WB);

    // The top bit of each extended result is carry-out (add) or borrow (sub, also A<B for SLT).
    assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_ext = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_ext[DATA_WIDTH-1:0];
                alu_carry = sum_ext[DATA_WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff_ext[DATA_WIDTH-1:0];
                alu_carry = diff_ext[DATA_WIDTH];
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, diff_ext[DATA_WIDTH]};
            default: alu_res = a_q;
        endcase
    end

    assign prod_next = prod + (mplier[0] ? mcand : '0);

`ifdef ALU_SEQ_DIV_EN
    // Restoring division: shift the next dividend bit into the remainder, subtract if it fits.
    assign rem_shift = {rem, quo[DATA_WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};
    assign no_borrow = ~rem_diff[DATA_WIDTH];
    assign rem_next  = no_borrow ? rem_diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
    assign quo_next  = {quo[DATA_WIDTH-2:0], no_borrow};
`endif

    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            state         <= S_IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt           <= '0;
            prod          <= '0;
            mcand         <= '0;
            mplier        <= '0;
            write_address <= '0;
            write_data    <= '0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            rem           <= '0;
            quo           <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q          <= op;
                        a_q           <= src_data1;
                        b_q           <= src_data2;
                        write_address <= dest_address;
                        cnt           <= '0;
                        prod          <= '0;
                        mcand         <= {{DATA_WIDTH{1'b0}}, src_data1};
                        mplier        <= src_data2;
`ifdef ALU_SEQ_DIV_EN
                        rem           <= '0;
                        quo           <= src_data1;
                        if (op == OP_DIV)
                            state <= S_DIV;
                        else
`endif
                        if (op == OP_MUL)
                            state <= S_MUL;
                        else
                            state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    write_data <= alu_res;
                    flag_zero  <= (alu_res == '0);
                    flag_carry <= alu_carry;
                    state      <= S_WB;
                end
                S_MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        write_data <= prod_next[DATA_WIDTH-1:0];
                        flag_zero  <= (prod_next[DATA_WIDTH-1:0] == '0);
                        flag_carry <= |prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
                        state      <= S_WB;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        if (b_q == '0) begin
                            write_data <= '1;
                            flag_zero  <= 1'b0;
                            flag_carry <= 1'b1;
                        end else begin
                            write_data <= quo_next;
                            flag_zero  <= (quo_next == '0);
                            flag_carry <= 1'b0;
                        end
                        state <= S_WB;
                    end
                end
`endif
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec; compile with ALU_SEQ_DIV_EN to cover the divider build.
module tb_alu_seq_exec;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] src_data1;
    logic [7:0] src_data2;
    logic [2:0] dest_address;
    logic       busy;
    logic       done;
    logic       write_enable;
    logic [2:0] write_address;
    logic [7:0] write_data;
    logic       flag_zero;
    logic       flag_carry;

    int checks   = 0;
    int errors   = 0;
    int we_count = 0;

    alu_seq_exec #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clock_reg     (clk),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .src_data1     (src_data1),
        .src_data2     (src_data2),
        .dest_address  (dest_address),
        .busy          (busy),
        .done          (done),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .flag_zero     (flag_zero),
        .flag_carry    (flag_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts write-enable cycles as seen by the register file at each rising edge.
    always @(posedge clk) if (write_enable === 1'b1) we_count++;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge while idle; issues one op and checks its write-back.
    task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] dest, input int exp_lat,
                          input logic [7:0] exp_data, input logic exp_z, input logic exp_c,
                          input bit poke);
        int cycles;
        int we_before;
        we_before    = we_count;
        start        = 1'b1;
        op           = o;
        src_data1    = a;
        src_data2    = b;
        dest_address = dest;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        check({name, " busy"}, busy, 1);
        src_data1 = 8'($urandom_range(0, 255));
        src_data2 = 8'($urandom_range(0, 255));
        op        = 3'b011;
        while (done !== 1'b1 && cycles < 40) begin
            start = (poke && cycles == 3);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check({name, " latency"}, cycles, exp_lat);
        check({name, " write_enable"}, write_enable, 1);
        check({name, " write_data"}, write_data, exp_data);
        check({name, " write_address"}, write_address, dest);
        check({name, " flag_zero"}, flag_zero, exp_z);
        check({name, " flag_carry"}, flag_carry, exp_c);
        @(negedge clk);
        check({name, " done pulse"}, done, 0);
        check({name, " idle after wb"}, busy, 0);
        check({name, " one write"}, we_count - we_before, 1);
    endtask

    initial begin
        int we_before;
        reset        = 1'b0;
        start        = 1'b0;
        op           = 3'b000;
        src_data1    = 8'h00;
        src_data2    = 8'h00;
        dest_address = 3'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset write_enable", write_enable, 0);
        check("reset write_address", write_address, 0);
        check("reset write_data", write_data, 0);
        check("reset flag_zero", flag_zero, 0);
        check("reset flag_carry", flag_carry, 0);

        reset     = 1'b1;
        we_before = we_count;
        repeat (10) @(negedge clk);
        check("idle busy", busy, 0);
        check("idle no writes", we_count - we_before, 0);

        // Reset in the middle of a multiply aborts it without a write-back.
        start     = 1'b1;
        op        = 3'b110;
        src_data1 = 8'h0C;
        src_data2 = 8'h0B;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", busy, 0);
        check("abort write_enable", write_enable, 0);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort no writes", we_count - we_before, 0);
        check("abort write_data", write_data, 0);
        check("abort busy later", busy, 0);

        run_op("add wrap", 3'b000, 8'hF0, 8'h20, 3'd3, 2, 8'h10, 1'b0, 1'b1, 1'b0);
        run_op("sub zero", 3'b001, 8'h55, 8'h55, 3'd1, 2, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("sub borrow", 3'b001, 8'h01, 8'h02, 3'd2, 2, 8'hFF, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("hold write_data", write_data, 8'hFF);
        check("hold flag_carry", flag_carry, 1);
        check("hold write_enable", write_enable, 0);

        run_op("and", 3'b010, 8'hCA, 8'h5F, 3'd4, 2, 8'h4A, 1'b0, 1'b0, 1'b0);
        run_op("or", 3'b011, 8'hCA, 8'h5F, 3'd5, 2, 8'hDF, 1'b0, 1'b0, 1'b0);
        run_op("xor", 3'b100, 8'hCA, 8'h5F, 3'd6, 2, 8'h95, 1'b0, 1'b0, 1'b0);
        run_op("slt true", 3'b101, 8'h05, 8'h80, 3'd7, 2, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op("slt false", 3'b101, 8'h80, 8'h05, 3'd0, 2, 8'h00, 1'b1, 1'b0, 1'b0);

        run_op("mul", 3'b110, 8'h0C, 8'h0B, 3'd5, 9, 8'h84, 1'b0, 1'b0, 1'b1);
        run_op("mul overflow", 3'b110, 8'h20, 8'h10, 3'd6, 9, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op("add after mul", 3'b000, 8'h01, 8'h02, 3'd2, 2, 8'h03, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SEQ_DIV_EN
        run_op("div", 3'b111, 8'h64, 8'h07, 3'd1, 9, 8'h0E, 1'b0, 1'b0, 1'b1);
        run_op("div by zero", 3'b111, 8'h64, 8'h00, 3'd2, 9, 8'hFF, 1'b0, 1'b1, 1'b0);
        run_op("div small", 3'b111, 8'h03, 8'h07, 3'd3, 9, 8'h00, 1'b1, 1'b0, 1'b0);
`else
        run_op("pass", 3'b111, 8'h64, 8'h07, 3'd1, 2, 8'h64, 1'b0, 1'b0, 1'b0);
        run_op("pass zero", 3'b111, 8'h00, 8'hFF, 3'd2, 2, 8'h00, 1'b1, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
